// File: rtl/ysyx_22050243_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - ifu_state_e      : fetch FSM states
//   - pc_sel_e         : next-PC select for the PC register
//   - DEFAULT_RESET_PC : default first fetch address after reset
//   - NOP_INST         : instruction presented to decode out of reset (addi x0,x0,0)
//   - INST_W           : instruction width
package ysyx_22050243_ifu_pkg;

  localparam int                INST_W           = 32;
  localparam logic [63:0]       DEFAULT_RESET_PC = 64'h8000_0000;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    HOLD
  } ifu_state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_REDIRECT
  } pc_sel_e;

endpackage

// File: rtl/ysyx_22050243_pc_reg.sv
// Program counter register with its next-PC mux.
//   clk, rst_n  : clock, asynchronous active-low reset (PC returns to RESET_PC)
//   pc_sel      : PC_HOLD keeps the PC, PC_INC advances by 4, PC_REDIRECT loads
//                 redirect_pc with its two low bits cleared
//   redirect_pc : redirect target from execute
//   pc_o        : current PC
module ysyx_22050243_pc_reg
  import ysyx_22050243_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst_n,
  input  pc_sel_e         pc_sel,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      // Natural wrap at 2^XLEN: the top PC word is followed by address 0.
      PC_INC:      pc_d = pc_q + XLEN'(4);
      // Fetches are word aligned, so the low two target bits are discarded.
      PC_REDIRECT: pc_d = redirect_pc & ~XLEN'(3);
      default:     pc_d = pc_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22050243_ifu.sv
// Instruction fetch unit for the RV64I core.
// Owns the PC, issues one word fetch at a time to instruction memory and holds
// the returned instruction for decode until it is taken or killed by a redirect.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr     : fetch request (addr always word aligned)
//   imem_rsp_valid/data           : fetch response
//   redirect_valid/pc             : PC change from execute (jal, jalr, taken branch)
//   id_valid/ready, id_pc/id_inst : instruction handed to decode
module ysyx_22050243_ifu
  import ysyx_22050243_ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst
);

  ifu_state_e        state_d, state_q;
  logic [INST_W-1:0] inst_d, inst_q;
  pc_sel_e           pc_sel;
  logic [XLEN-1:0]   pc;

  ysyx_22050243_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc),
    .pc_o        (pc)
  );

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc_sel  = PC_HOLD;
    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        if (redirect_valid) pc_sel = PC_REDIRECT;
        // An accepted request always returns a response; if the PC moved in
        // the same cycle that response belongs to the old path and must be
        // swallowed in DROP.
        if (imem_req_ready) state_d = redirect_valid ? DROP : WAIT;
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_sel  = PC_REDIRECT;
          state_d = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = HOLD;
        end
      end

      DROP: begin
        if (redirect_valid) pc_sel = PC_REDIRECT;
        if (imem_rsp_valid) state_d = REQ;
      end

      HOLD: begin
        // Redirect wins over a decode handshake: the held instruction is on
        // the wrong path and must never be delivered.
        if (redirect_valid) begin
          pc_sel  = PC_REDIRECT;
          state_d = REQ;
        end else if (id_ready) begin
          pc_sel  = PC_INC;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc;
  // The only combinational path to an output: a redirect retracts the held
  // instruction within the same cycle.
  assign id_valid       = (state_q == HOLD) && !redirect_valid;
  assign id_pc          = pc;
  assign id_inst        = inst_q;

endmodule

// File: tb/tb_ysyx_22050243_ifu.sv
module tb_ysyx_22050243_ifu;
  import ysyx_22050243_ifu_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  ysyx_22050243_ifu #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_t;

  // Reference model: the delivered stream is the word sequence starting at the
  // most recent redirect target (or reset PC), each paired with memory content.
  fetch_t      exp_q[$];
  logic [63:0] model_next;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int acc_cyc     = 0;
  int last_dlv    = -1;
  bit lat_mode    = 1'b0;

  // Memory model controls
  int ready_pct   = 100;
  int dmin        = 1;
  int dmax        = 1;
  int force_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] * 32'h9E37_79B1;
    return h ^ a[63:32] ^ 32'h5A5A_0001;
  endfunction

  function automatic fetch_t mk(input logic [63:0] pc);
    fetch_t f;
    f.pc   = pc;
    f.inst = mem_word(pc);
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  bit          pend_valid = 1'b0;
  logic [63:0] pend_addr;
  int          pend_cnt;

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (pend_valid) begin
        if (pend_cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend_valid     = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (pend_valid || imem_rsp_valid) begin
        imem_req_ready = 1'b0;
      end else if (force_stall > 0) begin
        imem_req_ready = 1'b0;
        if (imem_req_valid) force_stall--;
      end else begin
        imem_req_ready = ($urandom_range(99) < ready_pct);
      end
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        pend_valid = 1'b1;
        pend_addr  = imem_req_addr;
        pend_cnt   = $urandom_range(dmax, dmin);
      end
    end
  end

  // Keep at least one expected entry available for the monitor.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        exp_q.push_back(mk(model_next));
        model_next += 64'd4;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    fetch_t e;
    bit     prev_id_valid;
    prev_id_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (lat_mode && id_valid && !prev_id_valid)
          check("lat_accept_to_id_valid", 64'(cyc - acc_cyc), 64'd2);
        if (imem_req_valid && imem_req_ready) begin
          acc_cyc = cyc;
          check("req_addr_align", {62'd0, imem_req_addr[1:0]}, 64'd0);
          if (!redirect_valid) begin
            if (exp_q.size() == 0) check("req_queue_nonempty", 64'(exp_q.size()), 64'd1);
            else check("req_addr", imem_req_addr, exp_q[0].pc);
          end
        end
        if (id_valid && id_ready) begin
          if (exp_q.size() == 0) begin
            check("dlv_queue_nonempty", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check("id_pc", id_pc, e.pc);
            check("id_inst", 64'(id_inst), 64'(e.inst));
          end
          if (lat_mode && last_dlv >= 0) check("throughput_cycles", 64'(cyc - last_dlv), 64'd3);
          last_dlv = cyc;
        end
        if (redirect_valid) check("id_valid_killed_by_redirect", 64'(id_valid), 64'd0);
        prev_id_valid = id_valid;
      end else begin
        prev_id_valid = 1'b0;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    exp_q.delete();
    model_next = tgt & ~64'd3;
    exp_q.push_back(mk(model_next));
    model_next += 64'd4;
  endtask

  task automatic reseed_reset();
    exp_q.delete();
    exp_q.push_back(mk(RST_PC));
    model_next = RST_PC + 64'd4;
  endtask

  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_cond_id(input string name, input bit need_ready);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (id_valid && (id_ready || !need_ready)) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] tgt;
    rst_n          = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    force_stall    = 4;
    reseed_reset();
    #1 rst_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_id_pc", id_pc, RST_PC);
    check("rst_id_inst", 64'(id_inst), 64'(NOP_INST));

    // Release; memory stalls the first request for 4 cycles
    lat_mode = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_valid", 64'(imem_req_valid), 64'd0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_req_valid", 64'(imem_req_valid), 64'd1);
      check("stall_req_addr", imem_req_addr, RST_PC);
      check("stall_id_valid", 64'(id_valid), 64'd0);
    end

    // Streaming at full rate: one instruction per three cycles
    repeat (15) step();
    lat_mode = 1'b0;

    // Redirect in WAIT, stale response two cycles later
    dmin = 3;
    dmax = 3;
    wait_accept("acc_before_wait_redirect");
    step();
    redirect(64'h8000_1002);
    step();
    wait_accept("acc_after_wait_redirect");
    check("wait_redirect_addr", imem_req_addr, 64'h8000_1000);

    // HOLD with decode stalled, then redirect (with id_ready high in that cycle)
    step();
    id_ready = 1'b0;
    dmin = 1;
    dmax = 1;
    wait_cond_id("reach_hold", 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("hold_id_valid", 64'(id_valid), 64'd1);
      step();
      @(negedge clk);
    end
    step();
    id_ready = 1'b1;
    redirect(64'h8000_0100);
    #1;
    check("hold_redirect_id_valid", 64'(id_valid), 64'd0);
    step();
    wait_accept("acc_after_hold_redirect");
    check("hold_redirect_addr", imem_req_addr, 64'h8000_0100);

    // PC wrap at the top of the address space
    step();
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    step();
    wait_cond_id("wrap_delivery", 1'b1);
    check("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_accept("acc_after_wrap");
    check("wrap_req_addr", imem_req_addr, 64'd0);

    // Reset while in WAIT, response lands after release
    dmin = 3;
    dmax = 3;
    step();
    redirect(64'h8000_0400);
    step();
    wait_accept("acc_before_reset");
    check("pre_reset_addr", imem_req_addr, 64'h8000_0400);
    step();
    rst_n = 1'b0;
    reseed_reset();
    @(negedge clk);
    check("midrst_id_inst", 64'(id_inst), 64'(NOP_INST));
    check("midrst_req_valid", 64'(imem_req_valid), 64'd0);
    check("midrst_req_addr", imem_req_addr, RST_PC);
    step();
    rst_n = 1'b1;
    dmin = 1;
    dmax = 1;
    @(negedge clk);
    @(negedge clk);
    check("stale_rsp_id_valid", 64'(id_valid), 64'd0);
    wait_accept("acc_after_midrst");
    check("midrst_first_addr", imem_req_addr, RST_PC);

    // Randomized traffic
    ready_pct = 70;
    dmin = 1;
    dmax = 4;
    for (int i = 0; i < 3000; i++) begin
      step();
      id_ready = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(3))
          0:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
          default: tgt = RST_PC + 64'($urandom_range(8191));
        endcase
        redirect(tgt);
      end
    end
    step();
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
